// File: rtl/keccak_pkg.sv
// keccak_pkg
//   Shared Keccak types used by the SHA3 core.
//   N        lane width in bits
//   plane    five lanes of one row, indexed plane[x]
//   state    five planes, indexed state[y][x]
//   LANES    number of lanes in a state
//   STATE_W  width of the flattened state string
//   lane_of  maps a lane number k of the flattened string to its (y, x) position
package keccak_pkg;

   parameter int N = 64;

   localparam int LANES   = 25;
   localparam int STATE_W = LANES * N;

   typedef logic [N-1:0] lane_t;
   typedef lane_t [4:0]  plane;
   typedef plane  [4:0]  state;

   typedef struct packed {
      logic [2:0] y;
      logic [2:0] x;
   } lane_pos_t;

   // Lane k of the string sits at row k/5, column k%5 of the state.
   function automatic lane_pos_t lane_of(input int k);
      lane_pos_t p;
      p.y = 3'(k / 5);
      p.x = 3'(k % 5);
      return p;
   endfunction

endpackage

// File: rtl/state_squeeze_serializer_pkg.sv
// state_squeeze_serializer_pkg
//   FSM encoding for the squeeze-side serializer.
//   ST_IDLE  waiting for a state on the input handshake
//   ST_SEND  streaming lanes of the captured state
package state_squeeze_serializer_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } fsm_t;

endpackage

// File: rtl/array_to_string.sv
// array_to_string
//   Purely combinational flatten of a 5x5 Keccak state into the 1600-bit string,
//   lane k = s[64*k +: 64] = st[k/5][k%5]. Inverse of the receive-side
//   string-to-array conversion.
// Ports
//   st  in   state        5x5 lanes, st[y][x]
//   s   out  [1599:0]     flattened string
module array_to_string
   import keccak_pkg::*;
(
   input  state               st,
   output logic [STATE_W-1:0] s
);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam lane_pos_t POS = lane_of(gi);
      assign s[N*gi +: N] = st[POS.y][POS.x];
   end

endmodule

// File: rtl/state_squeeze_serializer.sv
// state_squeeze_serializer
//   Squeeze-side output stage of the SHA3 core. Takes a finished Keccak state on a
//   valid/ready handshake, keeps its flattened 1600-bit string on s_out, and streams
//   the first OUT_LANES lanes, one per beat, towards the host output FIFO.
// Parameters
//   OUT_LANES  lanes emitted per state, 1..25
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_state is valid
//   in_ready   out  1      a state can be accepted this cycle
//   in_state   in   state  5x5 lanes, in_state[y][x]
//   s_out      out  1600   flattened string of the last accepted state
//   out_valid  out  1      out_data holds a lane
//   out_ready  in   1      sink accepts out_data
//   out_data   out  64     current lane, out_data[7:0] is the first digest byte
//   out_idx    out  5      index of the current lane
//   out_last   out  1      current beat is lane OUT_LANES-1
//   busy       out  1      streaming in progress
module state_squeeze_serializer
   import keccak_pkg::*;
   import state_squeeze_serializer_pkg::*;
#(
   parameter int OUT_LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  state               in_state,
   output logic [STATE_W-1:0] s_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [63:0]        out_data,
   output logic [4:0]         out_idx,
   output logic               out_last,
   output logic               busy
);

   localparam int         LANE_W   = N;
   localparam logic [4:0] LAST_IDX = 5'(OUT_LANES - 1);

   if (OUT_LANES < 1 || OUT_LANES > LANES) begin : g_bad_out_lanes
      $error("state_squeeze_serializer: OUT_LANES must be in 1..25");
   end

   fsm_t               fsm_reg;
   fsm_t               fsm_next;
   logic [STATE_W-1:0] s_out_reg;
   logic [STATE_W-1:0] shreg_reg;
   logic [4:0]         idx_reg;
   logic [STATE_W-1:0] flat;
   logic               accept;
   logic               beat;

   array_to_string u_flatten (
      .st (in_state),
      .s  (flat)
   );

   always_comb begin
      fsm_next  = fsm_reg;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b0;
      case (fsm_reg)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               fsm_next = ST_SEND;
            end
         end
         ST_SEND: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (idx_reg == LAST_IDX);
            // A new state may only enter as the final lane leaves, so digests
            // can run back to back without an idle cycle.
            in_ready  = out_last && out_ready;
            if (out_last && out_ready && !in_valid) begin
               fsm_next = ST_IDLE;
            end
         end
         default: fsm_next = ST_IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign beat   = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_reg   <= ST_IDLE;
         s_out_reg <= '0;
         shreg_reg <= '0;
         idx_reg   <= '0;
      end else begin
         fsm_reg <= fsm_next;
         if (accept) begin
            s_out_reg <= flat;
            shreg_reg <= flat;
            idx_reg   <= '0;
         end else if (beat) begin
            shreg_reg <= shreg_reg >> LANE_W;
            // Return to 0 after the final lane so the index never runs past OUT_LANES-1.
            idx_reg   <= out_last ? 5'd0 : idx_reg + 5'd1;
         end
      end
   end

   assign s_out    = s_out_reg;
   assign out_data = shreg_reg[63:0];
   assign out_idx  = idx_reg;

endmodule

// File: tb/tb_state_squeeze_serializer.sv
module tb_state_squeeze_serializer;
   import keccak_pkg::*;

   localparam logic [63:0] BASE_A = 64'hA5A5_0000_0000_0000;
   localparam logic [63:0] BASE_B = 64'h1111_0000_0000_0000;
   localparam logic [63:0] BASE_N = 64'h5A5A_0000_0000_0000;
   localparam logic [63:0] BASE_C = 64'hC3C3_0000_0000_0000;
   localparam logic [63:0] BASE_D = 64'hD00D_0000_0000_0000;
   localparam logic [63:0] BASE_E = 64'hE1E1_0000_0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // DUT with OUT_LANES=4
   logic               in_valid = 1'b0;
   logic               in_ready;
   state               in_state = '0;
   logic [STATE_W-1:0] s_out;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [63:0]        out_data;
   logic [4:0]         out_idx;
   logic               out_last;
   logic               busy;

   // DUT with OUT_LANES=25
   logic               iv25 = 1'b0;
   logic               ir25;
   state               st25 = '0;
   logic [STATE_W-1:0] so25;
   logic               ov25;
   logic               or25 = 1'b0;
   logic [63:0]        od25;
   logic [4:0]         oi25;
   logic               ol25;
   logic               busy25;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   state_squeeze_serializer #(.OUT_LANES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .s_out     (s_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   state_squeeze_serializer #(.OUT_LANES(25)) dut25 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv25),
      .in_ready  (ir25),
      .in_state  (st25),
      .s_out     (so25),
      .out_valid (ov25),
      .out_ready (or25),
      .out_data  (od25),
      .out_idx   (oi25),
      .out_last  (ol25),
      .busy      (busy25)
   );

   function automatic state mk_state(input logic [63:0] base);
      state s;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            s[y][x] = base + 64'(5 * y + x);
         end
      end
      return s;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        ov;
      logic [4:0]  idx;
      logic        chk_data;
      logic [63:0] data;
      logic        last;
      logic        ir;
      logic        bsy;
   } vec_t;

   vec_t tbl [6];

   int          beats;
   logic [4:0]  exp_k;
   logic [6:0]  pat;

   initial begin
      // {iv, ordy, ov, idx, chk_data, data, last, ir, busy}
      tbl[0] = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 64'd0,       1'b0, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 5'd0, 1'b1, BASE_A + 0,  1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 5'd1, 1'b1, BASE_A + 1,  1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 5'd2, 1'b1, BASE_A + 2,  1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 5'd3, 1'b1, BASE_A + 3,  1'b1, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 64'd0,       1'b0, 1'b1, 1'b0};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_idx", 64'(out_idx), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_s_out0", s_out[63:0], 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      // 1: basic stream, table driven
      in_state = mk_state(BASE_A);
      for (int i = 0; i < 6; i++) begin
         in_valid  = tbl[i].iv;
         out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("t1_valid[%0d]", i), 64'(out_valid), 64'(tbl[i].ov));
         chk($sformatf("t1_idx[%0d]", i), 64'(out_idx), 64'(tbl[i].idx));
         chk($sformatf("t1_last[%0d]", i), 64'(out_last), 64'(tbl[i].last));
         chk($sformatf("t1_in_ready[%0d]", i), 64'(in_ready), 64'(tbl[i].ir));
         chk($sformatf("t1_busy[%0d]", i), 64'(busy), 64'(tbl[i].bsy));
         if (tbl[i].chk_data) chk($sformatf("t1_data[%0d]", i), out_data, tbl[i].data);
         @(negedge clk);
      end
      for (int k = 0; k < 25; k++) begin
         chk($sformatf("t1_s_out[%0d]", k), s_out[64*k +: 64], BASE_A + 64'(k));
      end

      // 2: backpressure 1,0,0,1,0,1,1
      in_valid = 1'b1;
      in_state = mk_state(BASE_B);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      pat = 7'b1101001;  // bit p is out_ready for cycle p
      exp_k = 5'd0;
      beats = 0;
      for (int p = 0; p < 7; p++) begin
         out_ready = pat[p];
         #1;
         chk($sformatf("t2_valid[%0d]", p), 64'(out_valid), 64'd1);
         chk($sformatf("t2_idx[%0d]", p), 64'(out_idx), 64'(exp_k));
         chk($sformatf("t2_data[%0d]", p), out_data, BASE_B + 64'(exp_k));
         chk($sformatf("t2_last[%0d]", p), 64'(out_last), 64'(exp_k == 5'd3));
         chk($sformatf("t2_in_ready[%0d]", p), 64'(in_ready), 64'((exp_k == 5'd3) && pat[p]));
         if (out_valid && out_ready) beats++;
         if (pat[p]) exp_k = exp_k + 5'd1;
         @(negedge clk);
      end
      #1;
      chk("t2_beats", 64'(beats), 64'd4);
      chk("t2_idle_valid", 64'(out_valid), 64'd0);
      @(negedge clk);

      // 3: back-to-back digests
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = mk_state(BASE_A);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            in_valid = 1'b1;
            in_state = mk_state(BASE_N);
         end
         #1;
         chk($sformatf("t3_a_data[%0d]", k), out_data, BASE_A + 64'(k));
         chk($sformatf("t3_a_idx[%0d]", k), 64'(out_idx), 64'(k));
         if (k == 3) chk("t3_in_ready_last", 64'(in_ready), 64'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("t3_n_valid[%0d]", k), 64'(out_valid), 64'd1);
         chk($sformatf("t3_n_data[%0d]", k), out_data, BASE_N + 64'(k));
         chk($sformatf("t3_n_idx[%0d]", k), 64'(out_idx), 64'(k));
         @(negedge clk);
      end
      #1;
      chk("t3_idle_valid", 64'(out_valid), 64'd0);
      chk("t3_s_out0", s_out[63:0], BASE_N);
      chk("t3_s_out24", s_out[64*24 +: 64], BASE_N + 64'd24);
      @(negedge clk);

      // 4: in_valid during beats 1-2 ignored
      in_valid = 1'b1;
      in_state = mk_state(BASE_A);
      @(negedge clk);
      in_state = mk_state(BASE_C);
      for (int k = 0; k < 4; k++) begin
         in_valid = (k == 1 || k == 2);
         #1;
         chk($sformatf("t4_data[%0d]", k), out_data, BASE_A + 64'(k));
         if (k == 1 || k == 2) chk($sformatf("t4_in_ready[%0d]", k), 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      chk("t4_idle_valid", 64'(out_valid), 64'd0);
      chk("t4_s_out3", s_out[64*3 +: 64], BASE_A + 64'd3);
      @(negedge clk);

      // 5: reset mid-stream
      in_valid = 1'b1;
      in_state = mk_state(BASE_A);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 64'(out_valid), 64'd0);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_idx", 64'(out_idx), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_in_ready", 64'(in_ready), 64'd1);
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_s_out0", s_out[63:0], 64'd0);
      chk("t5_s_out24", s_out[64*24 +: 64], 64'd0);
      in_valid = 1'b1;
      in_state = mk_state(BASE_D);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("t5_data[%0d]", k), out_data, BASE_D + 64'(k));
         chk($sformatf("t5_idx[%0d]", k), 64'(out_idx), 64'(k));
         @(negedge clk);
      end

      // 6: OUT_LANES=25
      iv25 = 1'b1;
      st25 = mk_state(BASE_E);
      or25 = 1'b1;
      @(negedge clk);
      iv25 = 1'b0;
      for (int k = 0; k < 25; k++) begin
         #1;
         chk($sformatf("t6_valid[%0d]", k), 64'(ov25), 64'd1);
         chk($sformatf("t6_data[%0d]", k), od25, BASE_E + 64'(k));
         chk($sformatf("t6_idx[%0d]", k), 64'(oi25), 64'(k));
         chk($sformatf("t6_last[%0d]", k), 64'(ol25), 64'(k == 24));
         @(negedge clk);
      end
      #1;
      chk("t6_idle_valid", 64'(ov25), 64'd0);
      chk("t6_idle_busy", 64'(busy25), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
